// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results queue in a FIFO.
// Publishes per-register pending mask and a starvation stall request.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wr,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_din,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_din,
    output logic        r3_wr,
    output logic [4:0]  r3_addr,
    output logic [31:0] r3_din,
    output logic [31:0] busy_mask,
    output logic        stall_req
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned PDW  = $clog2(DEPTH + 1);
    localparam int unsigned SW   = $clog2(STARVE_MAX + 1);
    localparam int unsigned NREG = 32;

    logic [4:0]     fifo_addr [DEPTH];
    logic [31:0]    fifo_data [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [PDW-1:0] pend [NREG];
    logic           r3_from_fifo;
    logic [SW-1:0]  starve;
    logic [SW-1:0]  starve_next;

    logic           pipe_win;
    logic           fifo_empty;
    logic           pop;
    logic           push;
    logic [4:0]     head_addr;
    logic [31:0]    head_data;
    logic [NREG-1:0] pend_inc;
    logic [NREG-1:0] pend_dec;

    assign mdu_ready  = (count < CW'(DEPTH));
    assign pipe_win   = pipe_wr & (pipe_addr != 5'd0);
    assign fifo_empty = (count == CW'(0));
    assign pop        = ~pipe_win & ~fifo_empty;
    assign push       = mdu_valid & mdu_ready & (mdu_addr != 5'd0);
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    // Starve counter: grows only while a queued entry is being blocked by the pipeline.
    always_comb begin
        starve_next = starve;
        if (pop || fifo_empty) begin
            starve_next = '0;
        end else if (starve < SW'(STARVE_MAX)) begin
            starve_next = starve + SW'(1);
        end
    end

    always_comb begin
        pend_inc  = '0;
        pend_dec  = '0;
        busy_mask = '0;
        for (int r = 0; r < NREG; r++) begin
            pend_inc[r]  = push && (mdu_addr == 5'(r));
            pend_dec[r]  = pop && (head_addr == 5'(r));
            busy_mask[r] = (pend[r] != PDW'(0)) ||
                           (r3_wr && r3_from_fifo && (r3_addr == 5'(r)));
        end
    end

    // FIFO storage carries no reset; validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mdu_addr;
            fifo_data[wr_ptr] <= mdu_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            r3_wr        <= 1'b0;
            r3_addr      <= '0;
            r3_din       <= '0;
            r3_from_fifo <= 1'b0;
            starve       <= '0;
            stall_req    <= 1'b0;
            for (int r = 0; r < NREG; r++) begin
                pend[r] <= '0;
            end
        end else begin
            count  <= count + CW'(push) - CW'(pop);
            starve <= starve_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            if (pipe_win) begin
                r3_wr        <= 1'b1;
                r3_addr      <= pipe_addr;
                r3_din       <= pipe_din;
                r3_from_fifo <= 1'b0;
            end else if (pop) begin
                r3_wr        <= 1'b1;
                r3_addr      <= head_addr;
                r3_din       <= head_data;
                r3_from_fifo <= 1'b1;
            end else begin
                r3_wr        <= 1'b0;
                r3_from_fifo <= 1'b0;
            end

            if (pop) begin
                stall_req <= 1'b0;
            end else if (starve_next == SW'(STARVE_MAX)) begin
                stall_req <= 1'b1;
            end

            for (int r = 0; r < NREG; r++) begin
                if (pend_inc[r] && !pend_dec[r]) begin
                    pend[r] <= pend[r] + PDW'(1);
                end else if (pend_dec[r] && !pend_inc[r]) begin
                    pend[r] <= pend[r] - PDW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vectors, corner sequences and random traffic
// compared against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wr;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_din;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_din;
    logic        r3_wr;
    logic [4:0]  r3_addr;
    logic [31:0] r3_din;
    logic [31:0] busy_mask;
    logic        stall_req;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_wr   (pipe_wr),
        .pipe_addr (pipe_addr),
        .pipe_din  (pipe_din),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .mdu_addr  (mdu_addr),
        .mdu_din   (mdu_din),
        .r3_wr     (r3_wr),
        .r3_addr   (r3_addr),
        .r3_din    (r3_din),
        .busy_mask (busy_mask),
        .stall_req (stall_req)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_wr;
        logic [4:0]  e_addr;
        logic [31:0] e_din;
        logic [31:0] e_busy;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    // Reference model state
    ent_t        q[$];
    logic        m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_din;
    logic        m_ff;
    int          m_starve;
    logic        m_stall;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_wr     = 1'b0;
        m_addr   = '0;
        m_din    = '0;
        m_ff     = 1'b0;
        m_starve = 0;
        m_stall  = 1'b0;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        foreach (q[i]) b[q[i].a] = 1'b1;
        if (m_wr && m_ff) b[m_addr] = 1'b1;
        return b;
    endfunction

    function automatic void model_edge(logic pw, logic [4:0] pa, logic [31:0] pd,
                                       logic mv, logic [4:0] ma, logic [31:0] md);
        int   n;
        logic win;
        logic popped;
        logic rdy;
        ent_t e;
        n      = q.size();
        win    = pw && (pa != 5'd0);
        rdy    = (n < DEPTH);
        popped = 1'b0;
        if (win) begin
            m_wr = 1'b1; m_addr = pa; m_din = pd; m_ff = 1'b0;
        end else if (n > 0) begin
            e = q.pop_front();
            m_wr = 1'b1; m_addr = e.a; m_din = e.d; m_ff = 1'b1;
            popped = 1'b1;
        end else begin
            m_wr = 1'b0; m_ff = 1'b0;
        end
        if (popped || n == 0) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        if (popped) m_stall = 1'b0;
        else if (m_starve == STARVE_MAX) m_stall = 1'b1;
        if (mv && rdy && ma != 5'd0) begin
            e.a = ma; e.d = md;
            q.push_back(e);
        end
    endfunction

    function automatic void check_model();
        chk("r3_wr",     r3_wr,     m_wr);
        chk("r3_addr",   r3_addr,   m_addr);
        chk("r3_din",    r3_din,    m_din);
        chk("busy_mask", busy_mask, model_busy());
        chk("mdu_ready", mdu_ready, (q.size() < DEPTH));
        chk("stall_req", stall_req, m_stall);
    endfunction

    task automatic step(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
        pipe_wr = pw; pipe_addr = pa; pipe_din = pd;
        mdu_valid = mv; mdu_addr = ma; mdu_din = md;
        @(posedge clk);
        model_edge(pw, pa, pd, mv, ma, md);
        #1;
        check_model();
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    vec_t tbl[4];

    initial begin
        // Priority/latency: MDU push (5) at cycle 0, pipeline write (7) at cycle 1.
        tbl[0] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hAAAA, 1'b0, 5'd0, 32'h0,    32'h20, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h1234, 32'h20, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hAAAA, 32'h20, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'hAAAA, 32'h0,  1'b1, 1'b0};

        rst = 1'b1;
        pipe_wr = 1'b0; pipe_addr = '0; pipe_din = '0;
        mdu_valid = 1'b0; mdu_addr = '0; mdu_din = '0;
        model_reset();
        #12;
        chk("rst_r3_wr",   r3_wr,     32'd0);
        chk("rst_r3_addr", r3_addr,   32'd0);
        chk("rst_r3_din",  r3_din,    32'd0);
        chk("rst_busy",    busy_mask, 32'd0);
        chk("rst_ready",   mdu_ready, 32'd1);
        chk("rst_stall",   stall_req, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            step(tbl[i].pw, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md);
            chk("vec_wr",    r3_wr,     tbl[i].e_wr);
            chk("vec_addr",  r3_addr,   tbl[i].e_addr);
            chk("vec_din",   r3_din,    tbl[i].e_din);
            chk("vec_busy",  busy_mask, tbl[i].e_busy);
            chk("vec_ready", mdu_ready, tbl[i].e_rdy);
            chk("vec_stall", stall_req, tbl[i].e_stall);
        end

        // Full, drain in order, then continuous push/pop across pointer wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'(10 + i), 32'hB000 + i);
        chk("full_ready", mdu_ready, 32'd0);
        step(1'b1, 5'd1, 32'h200, 1'b1, 5'd20, 32'hDEAD);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("drain_addr", r3_addr, 32'(10 + i));
            chk("drain_din",  r3_din,  32'hB000 + i);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(14 + i), 32'hC000 + i);
            if (i > 0) chk("wrap_din", r3_din, 32'hC000 + i - 1);
        end
        idle();
        chk("wrap_last", r3_din, 32'hC005);
        idle();

        // Register 0 filtering.
        step(1'b1, 5'd1, 32'h5, 1'b1, 5'd0, 32'h77);
        chk("r0_mdu_busy", busy_mask, 32'd0);
        idle();
        chk("r0_mdu_noq", r3_wr, 32'd0);
        step(1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33);
        step(1'b1, 5'd0, 32'h44, 1'b0, 5'd0, 32'h0);
        chk("r0_pipe_pop_wr",   r3_wr,   32'd1);
        chk("r0_pipe_pop_addr", r3_addr, 32'd3);
        chk("r0_pipe_pop_din",  r3_din,  32'h33);

        // Starvation: one queued entry blocked for STARVE_MAX cycles.
        step(1'b1, 5'd4, 32'h0, 1'b1, 5'd6, 32'h66);
        for (int i = 1; i <= STARVE_MAX; i++) begin
            step(1'b1, 5'd4, 32'(i), 1'b0, 5'd0, 32'h0);
            if (i == STARVE_MAX - 1) chk("starve_not_yet", stall_req, 32'd0);
        end
        chk("starve_set", stall_req, 32'd1);
        idle();
        chk("starve_commit", r3_addr, 32'd6);
        chk("starve_clear",  stall_req, 32'd0);
        idle();

        // Duplicate destination keeps busy until the last commit.
        step(1'b1, 5'd1, 32'h0, 1'b1, 5'd9, 32'h91);
        step(1'b1, 5'd1, 32'h0, 1'b1, 5'd9, 32'h92);
        idle();
        chk("dup_busy1", busy_mask[9], 32'd1);
        idle();
        chk("dup_busy2", busy_mask[9], 32'd1);
        chk("dup_din2",  r3_din, 32'h92);
        idle();
        chk("dup_busy3", busy_mask[9], 32'd0);

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) step(1'b1, 5'd1, 32'h0, 1'b1, 5'(20 + i), 32'hE000 + i);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_wr",    r3_wr,     32'd0);
        chk("midrst_busy",  busy_mask, 32'd0);
        chk("midrst_ready", mdu_ready, 32'd1);
        model_reset();
        pipe_wr = 1'b0; mdu_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("midrst_noq", r3_wr, 32'd0);
        end

        // Random traffic; second half leans toward pipeline-heavy to exercise starvation.
        for (int i = 0; i < 2000; i++) begin
            int pct;
            pct = (i < 1000) ? 50 : 88;
            step(($urandom_range(99) < pct), 5'($urandom_range(31)), $urandom,
                 ($urandom_range(99) < 60), 5'($urandom_range(31)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
